// File: rtl/mux_select_arbiter.sv
// Two-channel grant arbiter that drives the sel/en pins of a downstream 2:1 mux.
// Tied requests are resolved round-robin. A channel holding the grant yields after HOLD_CYCLES cycles if the other channel is waiting.
module mux_select_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  output logic sel,
  output logic en,
  output logic gnt0,
  output logic gnt1,
  output logic sw_pulse
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_gnt_q, last_gnt_d;
  logic             sel_q, sel_d;
  logic             sw_q, sw_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_gnt_q <= 1'b1;
      sel_q      <= 1'b0;
      sw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      sel_q      <= sel_d;
      sw_q       <= sw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    sel_d      = sel_q;
    sw_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_gnt_q ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0: begin
        if (!req0)                         state_d = req1 ? GRANT1 : IDLE;
        else if (req1 && cnt_q == CNT_LAST) state_d = GRANT1;
      end
      GRANT1: begin
        if (!req1)                         state_d = req0 ? GRANT0 : IDLE;
        else if (req0 && cnt_q == CNT_LAST) state_d = GRANT0;
      end
      default: state_d = IDLE;
    endcase

    // A change of state restarts the hold window. Staying in a grant advances it and wraps at the limit.
    if (state_d != state_q) begin
      cnt_d = '0;
      if (state_d != IDLE) begin
        last_gnt_d = (state_d == GRANT1);
        sel_d      = (state_d == GRANT1);
        sw_d       = (state_q != IDLE);
      end
    end else if (state_q != IDLE) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign en       = (state_q != IDLE);
  assign sel      = sel_q;
  assign gnt0     = en & ~sel_q;
  assign gnt1     = en & sel_q;
  assign sw_pulse = sw_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// Bench for mux_select_arbiter: directed scenarios plus a random soak on two instances (HOLD_CYCLES = 4 and 1).
// Each instance is checked against a tenure-based reference model.
module tb_mux_select_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic req0, req1;
  logic sel_w[2], en_w[2], gnt0_w[2], gnt1_w[2], sw_w[2];

  int n_cmp = 0;
  int n_err = 0;

  // Reference state per instance: owner (-1 none), cycles held since entry, last granted, sel, pulse.
  int   hcfg[2] = '{4, 1};
  int   m_own[2];
  int   m_n[2];
  int   m_last[2];
  logic m_sel[2];
  logic m_sw[2];

  always #5 clk = ~clk;

  mux_select_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) u0 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .sel(sel_w[0]), .en(en_w[0]), .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .sw_pulse(sw_w[0])
  );

  mux_select_arbiter #(.HOLD_CYCLES(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .sel(sel_w[1]), .en(en_w[1]), .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .sw_pulse(sw_w[1])
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = -1;
      m_n[k]    = 0;
      m_last[k] = 1;
      m_sel[k]  = 1'b0;
      m_sw[k]   = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic r0, input logic r1);
    int   nxt;
    logic rx, ro;
    nxt = m_own[k];
    if (m_own[k] < 0) begin
      if (r0 && r1)  nxt = 1 - m_last[k];
      else if (r0)   nxt = 0;
      else if (r1)   nxt = 1;
    end else begin
      rx = (m_own[k] == 0) ? r0 : r1;
      ro = (m_own[k] == 0) ? r1 : r0;
      if (!rx)                             nxt = ro ? 1 - m_own[k] : -1;
      else if (ro && (m_n[k] % hcfg[k]) == 0) nxt = 1 - m_own[k];
    end
    m_sw[k] = (m_own[k] >= 0) && (nxt >= 0) && (nxt != m_own[k]);
    if (nxt != m_own[k]) begin
      m_n[k] = (nxt < 0) ? 0 : 1;
      if (nxt >= 0) m_last[k] = nxt;
    end else if (nxt >= 0) begin
      m_n[k]++;
    end
    if (nxt >= 0) m_sel[k] = logic'(nxt);
    m_own[k] = nxt;
  endtask

  function automatic int exp_cnt(input int k);
    return (m_own[k] < 0) ? 0 : (m_n[k] - 1) % hcfg[k];
  endfunction

  task automatic check_dut(input int k);
    string p;
    p = (k == 0) ? "h4" : "h1";
    chk({p, ".en"},   int'(en_w[k]),   int'(m_own[k] >= 0));
    chk({p, ".sel"},  int'(sel_w[k]),  int'(m_sel[k]));
    chk({p, ".gnt0"}, int'(gnt0_w[k]), int'(m_own[k] == 0));
    chk({p, ".gnt1"}, int'(gnt1_w[k]), int'(m_own[k] == 1));
    chk({p, ".sw"},   int'(sw_w[k]),   int'(m_sw[k]));
    chk({p, ".cnt"},  (k == 0) ? int'(u0.cnt_q) : int'(u1.cnt_q), exp_cnt(k));
  endtask

  task automatic cyc();
    logic r0, r1;
    @(posedge clk);
    r0 = req0;
    r1 = req1;
    model_step(0, r0, r1);
    model_step(1, r0, r1);
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    model_rst();
    check_dut(0);
    check_dut(1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   run_len;
    int   prev_g;
    logic other_req;
    int   exp_g[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    model_rst();
    #2;
    check_dut(0);
    check_dut(1);
    chk("rst.last_gnt", int'(u0.last_gnt_q), 1);

    // Release reset with both channels requesting. The tie goes to channel 0, then the grant rotates every 4 cycles.
    @(negedge clk);
    rst  = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("both.grant", int'(sel_w[0]), exp_g[i]);
      chk("both.en", int'(en_w[0]), 1);
      chk("both.sw", int'(sw_w[0]), int'(i == 4 || i == 8));
      chk("h1.alt", int'(sel_w[1]), i % 2);
      if (i > 0) chk("h1.sw", int'(sw_w[1]), 1);
    end

    // A lone request on channel 1 keeps the grant, and the counter wraps.
    apply_reset();
    req0 = 1'b0;
    req1 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("r1only.sel", int'(sel_w[0]), 1);
      chk("r1only.sw", int'(sw_w[0]), 0);
      chk("r1only.cnt", int'(u0.cnt_q), i % 4);
    end

    // Channel 0 drops its request at counter 1 while channel 1 waits.
    apply_reset();
    req0 = 1'b1;
    req1 = 1'b0;
    cyc();
    cyc();
    chk("drop.cnt_before", int'(u0.cnt_q), 1);
    req0 = 1'b0;
    req1 = 1'b1;
    cyc();
    chk("drop.sel", int'(sel_w[0]), 1);
    chk("drop.sw", int'(sw_w[0]), 1);
    chk("drop.cnt", int'(u0.cnt_q), 0);

    // A short reset pulse between edges in GRANT1 drops en and sel without waiting for a clock edge.
    cyc();
    chk("pre_pulse.gnt1", int'(gnt1_w[0]), 1);
    rst = 1'b1;
    #1;
    chk("pulse.en", int'(en_w[0]), 0);
    chk("pulse.sel", int'(sel_w[0]), 0);
    #2;
    rst = 1'b0;
    model_rst();
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_pulse.en", int'(en_w[0]), 0);
    end

    // Random soak. Each tenure is also checked independently of the model.
    run_len = 0;
    prev_g  = -1;
    for (int i = 0; i < 10000; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      other_req = 1'b0;
      cyc();
      chk("rnd.excl", int'(gnt0_w[0] & gnt1_w[0]), 0);
      chk("rnd.en_gnt", int'(en_w[0]), int'(gnt0_w[0] | gnt1_w[0]));
      if (gnt0_w[0] || gnt1_w[0]) begin
        other_req = gnt0_w[0] ? req1 : req0;
        if ((gnt1_w[0] ? 1 : 0) == prev_g) run_len++;
        else run_len = 1;
        prev_g = gnt1_w[0] ? 1 : 0;
        // Once the held channel has had 4 cycles, a waiting request must take the grant at the next edge.
        if (other_req && run_len >= 4 && (run_len % 4) == 0) begin
          @(posedge clk);
          model_step(0, req0, req1);
          model_step(1, req0, req1);
          #1;
          check_dut(0);
          check_dut(1);
          chk("rnd.yield", int'(gnt1_w[0] ? 1 : 0), 1 - prev_g);
          run_len = 1;
          prev_g  = gnt1_w[0] ? 1 : 0;
        end
      end else begin
        prev_g  = -1;
        run_len = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_select_arbiter.md
MUX_SELECT_ARBITER -- requirements
Module: mux_select_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4: maximum consecutive cycles one channel keeps the grant while the other channel is requesting; legal range 1..(2^CNT_W)-1.
REQ-002 Parameter CNT_W, default 3: hold-counter width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req0  input  1  channel-0 request; level, sampled on rising clk.
REQ-006 req1  input  1  channel-1 request; level, sampled on rising clk.
REQ-007 sel  output  1  mux select, drives downstream 2:1 mux sel (0 = in0, 1 = in1); registered.
REQ-008 en  output  1  mux enable, drives downstream mux en (0 forces mux output to 0); registered.
REQ-009 gnt0  output  1  high while channel 0 is granted; equals en & ~sel.
REQ-010 gnt1  output  1  high while channel 1 is granted; equals en & sel.
REQ-011 sw_pulse  output  1  one-cycle pulse on a direct grant hand-over between channels.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT0, GRANT1; outputs SHALL be Moore-decoded from registered state (no combinational path from req0/req1 to any output).
REQ-013 Outputs per state SHALL be:
- IDLE: en=0; sel holds its last value.
- GRANT0: en=1, sel=0.
- GRANT1: en=1, sel=1.
REQ-014 A 1-bit pointer last_gnt SHALL record the most recently granted channel and is updated on every entry into GRANT0 or GRANT1.
REQ-015 Transitions from IDLE SHALL be:
- req0 only -> GRANT0.
- req1 only -> GRANT1.
- both -> the channel opposite last_gnt.
- neither -> stay in IDLE.
REQ-016 A 0-to-1 request edge SHALL produce en=1 exactly one cycle after the edge at which the request is first sampled high (latency 1 clk).
REQ-017 The hold counter SHALL clear to 0 on every entry into a GRANT state and increment by 1 on each cycle spent in that GRANT state.
REQ-018 In GRANTx, if reqx=0, the FSM SHALL go to GRANT(other) when the other channel requests, else to IDLE.
REQ-019 In GRANTx with reqx=1, when counter == HOLD_CYCLES-1 and the other channel requests, the FSM SHALL hand over to GRANT(other).
REQ-020 In GRANTx with reqx=1, when counter == HOLD_CYCLES-1 and the other channel does not request, the FSM SHALL stay in GRANTx and the counter SHALL wrap to 0.
REQ-021 In GRANTx with reqx=1 and counter < HOLD_CYCLES-1, the FSM SHALL stay in GRANTx regardless of the other request.
REQ-022 sw_pulse SHALL be high for exactly the first cycle of a GRANT0<->GRANT1 direct transition; it SHALL stay 0 for IDLE->GRANT and GRANT->IDLE transitions.
REQ-023 With HOLD_CYCLES=1 and both channels requesting continuously, the grant SHALL alternate every cycle and sw_pulse SHALL stay high.
REQ-024 The counter SHALL never exceed HOLD_CYCLES-1 and SHALL never overflow CNT_W bits.

Reset
REQ-025 While rst=1, regardless of clk, the block SHALL hold: state=IDLE, sel=0, en=0, gnt0=0, gnt1=0, sw_pulse=0, counter=0, last_gnt=1.
REQ-026 Reset asserted mid-grant SHALL drop en to 0 immediately (asynchronously), without waiting for a clock edge.
REQ-027 After rst deasserts, the first rising edge SHALL evaluate the IDLE transitions of REQ-015.

Verification (HOLD_CYCLES=4)
REQ-028 Reset release with req0=req1=1 at the first edge -> GRANT0 (tie goes to channel 0 since last_gnt=1); en=1, sel=0 after one edge.
REQ-029 Both channels requesting continuously for 12 cycles -> grant pattern 0,0,0,0,1,1,1,1,0,0,0,0; sw_pulse high at cycles 5 and 9 only.
REQ-030 req1 only, held for 10 cycles -> GRANT1 for all 10 cycles; counter wraps 0..3; sw_pulse stays 0.
REQ-031 In GRANT0 at counter=1, req0 drops while req1=1 -> next cycle GRANT1, sel=1, sw_pulse=1, counter=0.
REQ-032 In GRANT1, rst pulsed for 3 ns between clock edges -> en=0 and sel=0 within the pulse; after release with no requests the block stays in IDLE.
REQ-033 Random req0/req1 for 10k cycles -> checker confirms gnt0 & gnt1 never both high, no grant longer than 4 cycles while the other channel is requesting, and en=0 whenever the block is in IDLE.
